// File: rtl/vga_rect_fill_if.sv
// ---------------------------------------------------------------------------
// vga_rect_fill_if
// Command and pixel bus between a rectangle-fill producer and its client.
//   start/x0/y0/w/h/color : rectangle command, qualified by start while ready=1
//   ready/done            : idle indication and one-cycle completion pulse
//   VGA_X/VGA_Y/VGA_COLOR : pixel coordinate and colour, qualified by plot
// The master modport issues commands; the slave modport is the fill engine.
// ---------------------------------------------------------------------------
interface vga_rect_fill_if #(
  parameter int XW = 8,
  parameter int YW = 7
) ();
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] w;
  logic [YW-1:0] h;
  logic [2:0]    color;
  logic          ready;
  logic          done;
  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [2:0]    VGA_COLOR;
  logic          plot;

  modport master (
    output start, x0, y0, w, h, color,
    input  ready, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );

  modport slave (
    input  start, x0, y0, w, h, color,
    output ready, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );
endinterface

// File: rtl/vga_rect_fill.sv
// ---------------------------------------------------------------------------
// vga_rect_fill
// Rectangle pixel-write generator feeding the VGA pixel ports. A command
// (origin, size, colour) is accepted with start while ready=1, then one pixel
// is emitted per clock in row-major order. Pixels outside XRES x YRES still
// take their cycle but are not plotted. done pulses for one cycle at the end.
//
// Ports:
//   CLOCK_50 : clock, all state on the rising edge
//   Reset    : asynchronous, active-high reset (aborts a draw, no done)
//   bus      : vga_rect_fill_if.slave (command in, pixel stream out)
//
// Optional feature (macro VGA_CLEAR_ON_RESET_EN): after reset the block
// sweeps the whole screen with colour 0, pulses done, then becomes idle.
// ---------------------------------------------------------------------------
module vga_rect_fill #(
  parameter int XRES = 160,
  parameter int YRES = 120,
  parameter int XW   = 8,
  parameter int YW   = 7
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  vga_rect_fill_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;
`ifdef VGA_CLEAR_ON_RESET_EN
  localparam logic [1:0] CLEAR = 2'd3;
  localparam logic [1:0] RESET_STATE = CLEAR;
`else
  localparam logic [1:0] RESET_STATE = IDLE;
`endif

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [YW-1:0] y0_q, y0_d;
  logic [XW-1:0] w_q, w_d;
  logic [YW-1:0] h_q, h_d;
  logic [2:0]    color_q, color_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [2:0]    vga_color_q, vga_color_d;
  logic          plot_q, plot_d;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
`ifdef VGA_CLEAR_ON_RESET_EN
  // Set once the last clear pixel has been issued, so the next cycle is FIN.
  logic          clr_last_q, clr_last_d;
`endif

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    plot_d      = 1'b0;
    sum_x       = '0;
    sum_y       = '0;
`ifdef VGA_CLEAR_ON_RESET_EN
    clr_last_d  = clr_last_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          w_d     = bus.w;
          h_d     = bus.h;
          color_d = bus.color;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (bus.w == '0 || bus.h == '0) ? FIN : DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        // cx/cy name the pixel on the outputs now; advance to the next one.
        if (cx_q == w_q - XW'(1)) begin
          cx_d = '0;
          if (cy_q == h_q - YW'(1)) begin
            state_d = FIN;
          end else begin
            cy_d = cy_q + YW'(1);
          end
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
`ifdef VGA_CLEAR_ON_RESET_EN
      CLEAR: begin
        // Here cx/cy name the next pixel to issue rather than the shown one,
        // because the cycle right after reset carries no pixel.
        if (clr_last_q) begin
          state_d    = FIN;
          clr_last_d = 1'b0;
        end else begin
          vga_x_d     = cx_q;
          vga_y_d     = cy_q;
          vga_color_d = 3'd0;
          plot_d      = 1'b1;
          if (cx_q == XW'(XRES - 1)) begin
            cx_d = '0;
            if (cy_q == YW'(YRES - 1)) begin
              clr_last_d = 1'b1;
              cy_d       = '0;
            end else begin
              cy_d = cy_q + YW'(1);
            end
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Pixel outputs are registered from next-state values so the first
    // pixel appears in the cycle right after the accepting edge.
    if (state_d == DRAW) begin
      sum_x       = {1'b0, x0_d} + {1'b0, cx_d};
      sum_y       = {1'b0, y0_d} + {1'b0, cy_d};
      vga_x_d     = sum_x[XW-1:0];
      vga_y_d     = sum_y[YW-1:0];
      vga_color_d = color_d;
      plot_d      = (sum_x < (XW+1)'(XRES)) && (sum_y < (YW+1)'(YRES));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= RESET_STATE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      plot_q      <= 1'b0;
`ifdef VGA_CLEAR_ON_RESET_EN
      clr_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      plot_q      <= plot_d;
`ifdef VGA_CLEAR_ON_RESET_EN
      clr_last_q  <= clr_last_d;
`endif
    end
  end

  assign bus.ready     = (state_q == IDLE) || (state_q == FIN);
  assign bus.done      = (state_q == FIN);
  assign bus.VGA_X     = vga_x_q;
  assign bus.VGA_Y     = vga_y_q;
  assign bus.VGA_COLOR = vga_color_q;
  assign bus.plot      = plot_q;

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Pixel-write generator that sits directly upstream of the DESim VGA output ports (VGA_X, VGA_Y, VGA_COLOR, plot).
- Accepts a rectangle command (origin, size, colour) over a start/ready handshake.
- Emits one pixel write per clock in row-major order.
- Replaces hand-written pixel FSMs inside demo cores; the top level wires its outputs straight to the VGA ports.

Parameters:
- XRES, 160, visible columns; pixels with x >= XRES are clipped.
- YRES, 120, visible rows; pixels with y >= YRES are clipped.
- XW, 8, x coordinate and width bit-width (10 for 640x480, 9 for 320x240).
- YW, 7, y coordinate and height bit-width (XW-1).

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only when ready=1.
- x0  in  XW  rectangle left column.
- y0  in  YW  rectangle top row.
- w  in  XW  width in pixels; 0 means empty.
- h  in  YW  height in pixels; 0 means empty.
- color  in  3  RGB colour for the rectangle.
- ready  out  1  block idle, can accept start.
- done  out  1  one-cycle pulse when a command completes.
- VGA_X  out  XW  pixel column.
- VGA_Y  out  YW  pixel row.
- VGA_COLOR  out  3  pixel colour.
- plot  out  1  write strobe for the current VGA_X/VGA_Y/VGA_COLOR.

Behaviour:
- Reset values:
  - ready=1, done=0, plot=0.
  - VGA_X=0, VGA_Y=0, VGA_COLOR=0.
  - State IDLE, or CLEAR when the optional feature is enabled.
  - Reset is asynchronous; asserting it mid-draw aborts immediately, with no done pulse.
- States: IDLE, DRAW, FIN.
- IDLE:
  - ready=1.
  - On start at edge T: latch x0, y0, w, h, color; set column/row counters to 0.
  - If w==0 or h==0, go to FIN; otherwise go to DRAW.
  - ready=0 from T+1.
- DRAW:
  - One pixel per cycle, starting on cycle T+1.
  - Registered outputs: VGA_X = x0+cx, VGA_Y = y0+cy, VGA_COLOR = latched color.
  - cx increments each cycle. When cx==w-1, cx returns to 0 and cy increments.
  - After the pixel with cx==w-1 and cy==h-1, go to FIN.
  - Total DRAW cycles are exactly w*h.
- Clipping:
  - Sums are computed one bit wider than XW/YW.
  - plot=1 only if x0+cx < XRES and y0+cy < YRES; otherwise plot=0 for that cycle.
  - Clipped pixels still consume their cycle, so timing does not depend on position.
  - VGA_X/VGA_Y carry the truncated sum; only plot qualifies them.
- FIN:
  - Lasts one cycle: done=1, plot=0, ready=1.
  - A start in this cycle is accepted, identically to IDLE; otherwise go to IDLE.
  - Completion: done is high at T+w*h+1. For an empty command, done is high at T+1.
- Busy: start while ready=0 is ignored, and command inputs are not sampled.
- plot is 0 in IDLE and FIN. VGA_X/VGA_Y/VGA_COLOR hold their last values outside DRAW.

Optional Feature:
- Macro: VGA_CLEAR_ON_RESET_EN.
- Defined:
  - Leaving reset, the block enters state CLEAR with ready=0.
  - It sweeps every pixel (0..XRES-1, 0..YRES-1) in row-major order with VGA_COLOR=0 and plot=1: XRES*YRES cycles.
  - It then spends one FIN cycle with done=1, then goes to IDLE.
  - start is ignored during CLEAR.
- Not defined: there is no CLEAR state, and ready=1 in the first cycle after reset.

Test Plan:
- Reset, then idle 5 cycles -> ready=1, plot=0, done=0 throughout; VGA outputs 0.
- start with x0=10, y0=20, w=2, h=3, color=3'b100 at T -> T+1..T+6 plot=1 at (10,20), (11,20), (10,21), (11,21), (10,22), (11,22), colour 4; done=1 at T+7; ready=1 at T+7.
- start with w=0, h=5 -> no plot; done=1 at T+1; second command issued in that FIN cycle is accepted and drawn from T+2.
- Clipping: x0=158, y0=118, w=4, h=3 -> 12 DRAW cycles; plot=1 only for (158,118), (159,118), (158,119), (159,119); done at T+13.
- start pulsed while drawing w=4, h=4 -> ignored; exactly 16 pixels drawn. Reset asserted at pixel 7 -> plot drops asynchronously; no done pulse; ready=1 after release.
- With VGA_CLEAR_ON_RESET_EN -> 19200 plot cycles of colour 0 covering (0,0)..(159,119), then done pulse, then ready=1; start during the sweep ignored.
